shift_register_prog_delay: RTL and testbench

- Programmable-latency, stallable delay line with a valid sideband and a frame-last sideband.
- Successor to the fixed-depth valid shift register. Used to align data paths in the FFT pipeline (twiddle/butterfly path skew) when the latency depends on the FFT size configured at runtime.
- Adds:
  - clock-enable stall;
  - runtime delay selection, applied safely only when no data is in flight;
  - synchronous flush;
  - an in-flight counter.

---
 rtl/shift_register_prog_delay_if.sv | 30 +++
 rtl/shift_register_prog_delay.sv | 135 +++++++++++++
 tb/tb_shift_register_prog_delay.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_register_prog_delay_if.sv
// Bundle of the delay-line control, input and output signals.
// The master side (producer/controller) drives the inputs; the slave side is the delay line.
interface shift_register_prog_delay_if #(
  parameter int WIDTH = 256,
  parameter int DLY_W = 4
);
  logic             en;
  logic             flush;
  logic             dly_load;
  logic [DLY_W-1:0] dly_sel;
  logic             in_valid;
  logic             in_last;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_last;
  logic [WIDTH-1:0] out_data;
  logic [DLY_W-1:0] cur_dly;
  logic             dly_pending;
  logic [DLY_W-1:0] in_flight;

  modport master (
    output en, flush, dly_load, dly_sel, in_valid, in_last, in_data,
    input  out_valid, out_last, out_data, cur_dly, dly_pending, in_flight
  );

  modport slave (
    input  en, flush, dly_load, dly_sel, in_valid, in_last, in_data,
    output out_valid, out_last, out_data, cur_dly, dly_pending, in_flight
  );
endinterface

// File: rtl/shift_register_prog_delay.sv
// Programmable-latency, stallable delay line with valid and frame-last sidebands.
// The output tap is selected by cur_dly; a new delay is only switched in once the
// active part of the pipeline is empty, so no word is duplicated or dropped.
module shift_register_prog_delay #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 10,
  parameter int DLY_W = $clog2(DEPTH + 1)
) (
  input logic                        clk,
  input logic                        rst,
  shift_register_prog_delay_if.slave bus
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_WAIT = 1'b1;
  localparam logic [DLY_W-1:0] DEPTH_C = DLY_W'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [0:0]       state_q, state_d;
  logic [DLY_W-1:0] cur_dly_q, cur_dly_d;
  logic [DLY_W-1:0] pend_dly_q, pend_dly_d;
  logic [DLY_W-1:0] in_flight_q, in_flight_d;

  logic             in_vld_eff;
  logic             tap_valid;
  logic             tap_last;
  logic [WIDTH-1:0] tap_data;
  logic             apply_c;
  logic [DLY_W-1:0] sel_clamped;

  // Map an out-of-range delay request onto the legal range 1..DEPTH.
  function automatic logic [DLY_W-1:0] clamp_dly(input logic [DLY_W-1:0] sel);
    if (sel == '0) return DLY_W'(1);
    if (sel > DEPTH_C) return DEPTH_C;
    return sel;
  endfunction

  // A stalled pipeline ignores in_valid entirely.
  assign in_vld_eff  = bus.in_valid & bus.en;
  assign sel_clamped = clamp_dly(bus.dly_sel);

  // Switch delay only when the counted stages are empty and nothing enters this cycle;
  // flush has priority and defers the switch to the following edge.
  assign apply_c = (state_q == ST_WAIT) && (in_flight_q == '0) && !in_vld_eff && !bus.flush;

  // Output tap mux: stage cur_dly-1 drives the outputs directly.
  always_comb begin
    tap_valid = 1'b0;
    tap_last  = 1'b0;
    tap_data  = data_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (DLY_W'(i + 1) == cur_dly_q) begin
        tap_valid = valid_q[i];
        tap_last  = last_q[i];
        tap_data  = data_q[i];
      end
    end
  end

  // Control next-state: flush, then delay apply, then normal shift/count.
  always_comb begin
    valid_d     = valid_q;
    last_d      = last_q;
    state_d     = state_q;
    cur_dly_d   = cur_dly_q;
    pend_dly_d  = pend_dly_q;
    in_flight_d = in_flight_q;
    if (bus.flush) begin
      valid_d     = '0;
      last_d      = '0;
      in_flight_d = '0;
      if (bus.dly_load) begin
        pend_dly_d = sel_clamped;
        state_d    = ST_WAIT;
      end
    end else if (apply_c) begin
      // Stages past the old tap may still hold already-emitted words; drop them so a
      // longer delay cannot re-emit them. The counted range is empty, so the count is 0.
      cur_dly_d   = bus.dly_load ? sel_clamped : pend_dly_q;
      state_d     = ST_IDLE;
      valid_d     = '0;
      last_d      = '0;
      in_flight_d = '0;
    end else begin
      if (bus.dly_load) begin
        pend_dly_d = sel_clamped;
        state_d    = ST_WAIT;
      end
      if (bus.en) begin
        valid_d     = {valid_q[DEPTH-2:0], in_vld_eff};
        last_d      = {last_q[DEPTH-2:0], in_vld_eff & bus.in_last};
        in_flight_d = in_flight_q + DLY_W'(in_vld_eff) - DLY_W'(tap_valid);
      end
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q     <= '0;
      last_q      <= '0;
      state_q     <= ST_IDLE;
      cur_dly_q   <= DEPTH_C;
      pend_dly_q  <= DEPTH_C;
      in_flight_q <= '0;
    end else begin
      valid_q     <= valid_d;
      last_q      <= last_d;
      state_q     <= state_d;
      cur_dly_q   <= cur_dly_d;
      pend_dly_q  <= pend_dly_d;
      in_flight_q <= in_flight_d;
    end
  end

  // Data stages: shift on enable, never reset (qualified by the valid bits).
  always_ff @(posedge clk) begin
    if (bus.en) begin
      data_q[0] <= bus.in_data;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign bus.out_valid   = tap_valid;
  assign bus.out_last    = tap_valid & tap_last;
  assign bus.out_data    = tap_data;
  assign bus.cur_dly     = cur_dly_q;
  assign bus.dly_pending = (state_q == ST_WAIT);
  assign bus.in_flight   = in_flight_q;

endmodule

// File: tb/tb_shift_register_prog_delay.sv
// Bench for shift_register_prog_delay: a history-based model (words indexed by the
// enabled-shift count they entered on) checked every cycle, plus directed literal checks.
module tb_shift_register_prog_delay;
  localparam int WIDTH = 256;
  localparam int DEPTH = 10;
  localparam int DLY_W = $clog2(DEPTH + 1);
  localparam int HN    = 4096;
  typedef logic [WIDTH-1:0] w_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_register_prog_delay_if #(.WIDTH(WIDTH), .DLY_W(DLY_W)) bus ();

  shift_register_prog_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input w_t act, input w_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: word entered on enabled shift k is at the output once k + cur_dly shifts
  // have happened, unless a clear (reset/flush/delay switch) happened after it entered.
  bit   hv [HN];
  bit   hl [HN];
  w_t   hd [HN];
  int   S      = 0;
  int   clr    = 0;
  int   m_cur  = DEPTH;
  int   m_pend = DEPTH;
  bit   m_wait = 1'b0;
  bit   m_init = 1'b0;

  function automatic int m_clamp(int v);
    if (v < 1) return 1;
    if (v > DEPTH) return DEPTH;
    return v;
  endfunction

  function automatic bit m_live(int k);
    return (k >= 0) && (k >= clr) && (k < S) && hv[k];
  endfunction

  function automatic int m_flight();
    int c = 0;
    for (int k = S - m_cur; k < S; k++) if (m_live(k)) c++;
    return c;
  endfunction

  // Model update on each active edge from the inputs presented for it.
  always @(posedge clk) begin
    bit ev;
    int fl;
    if (!rst) begin
      clr    = S;
      m_cur  = DEPTH;
      m_wait = 1'b0;
      m_init = 1'b1;
    end else begin
      ev = bus.in_valid & bus.en;
      fl = m_flight();
      if (bus.flush) begin
        if (bus.dly_load) begin m_wait = 1'b1; m_pend = m_clamp(int'(bus.dly_sel)); end
        if (bus.en) begin hv[S] = 1'b0; hl[S] = 1'b0; hd[S] = '0; S++; end
        clr = S;
      end else if (m_wait && fl == 0 && !ev) begin
        m_cur  = bus.dly_load ? m_clamp(int'(bus.dly_sel)) : m_pend;
        m_wait = 1'b0;
        if (bus.en) begin hv[S] = 1'b0; hl[S] = 1'b0; hd[S] = '0; S++; end
        clr = S;
      end else begin
        if (bus.dly_load) begin m_wait = 1'b1; m_pend = m_clamp(int'(bus.dly_sel)); end
        if (bus.en) begin
          hv[S] = bus.in_valid;
          hl[S] = bus.in_valid & bus.in_last;
          hd[S] = bus.in_data;
          S++;
        end
      end
    end
  end

  // Compare process: DUT outputs vs model on every cycle after the first reset.
  w_t acc_q [$];
  bit last_seen = 1'b0;
  always @(negedge clk) begin
    int k;
    if (m_init) begin
      k = S - m_cur;
      chk("cmp_out_valid", w_t'(bus.out_valid), w_t'(m_live(k)));
      chk("cmp_out_last", w_t'(bus.out_last), w_t'(m_live(k) && hl[k]));
      if (m_live(k)) chk("cmp_out_data", bus.out_data, hd[k]);
      chk("cmp_cur_dly", w_t'(bus.cur_dly), w_t'(m_cur));
      chk("cmp_dly_pending", w_t'(bus.dly_pending), w_t'(m_wait));
      chk("cmp_in_flight", w_t'(bus.in_flight), w_t'(m_flight()));
    end
    if (rst && bus.en && bus.out_valid) acc_q.push_back(bus.out_data);
    if (bus.out_last) last_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en       = 1'b1;
    bus.flush    = 1'b0;
    bus.dly_load = 1'b0;
    bus.dly_sel  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic send(input w_t d, input bit l);
    bus.in_valid = 1'b1;
    bus.in_last  = l;
    bus.in_data  = d;
    tick();
    idle();
  endtask

  task automatic load(input int sel);
    bus.dly_load = 1'b1;
    bus.dly_sel  = DLY_W'(sel);
    tick();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    w_t hold;
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    chk("rst_out_valid", w_t'(bus.out_valid), w_t'(0));
    chk("rst_out_last", w_t'(bus.out_last), w_t'(0));
    chk("rst_cur_dly", w_t'(bus.cur_dly), w_t'(10));
    chk("rst_pending", w_t'(bus.dly_pending), w_t'(0));
    chk("rst_in_flight", w_t'(bus.in_flight), w_t'(0));

    // 1: single word at default delay
    send(w_t'(8'hA5), 1'b0);
    chk("t1_flight_1", w_t'(bus.in_flight), w_t'(1));
    n = 1;
    while (!bus.out_valid && n < 30) begin tick(); n++; end
    chk("t1_latency", w_t'(n), w_t'(10));
    chk("t1_data", bus.out_data, w_t'(8'hA5));
    tick();
    chk("t1_one_cycle", w_t'(bus.out_valid), w_t'(0));
    chk("t1_flight_0", w_t'(bus.in_flight), w_t'(0));

    // 2: stream 1..20 with a 3-cycle stall while outputs are valid
    acc_q.delete();
    for (int w = 1; w <= 20; w++) begin
      if (w == 15) begin
        hold = bus.out_data;
        chk("t2_pre_stall_data", hold, w_t'(5));
        bus.in_valid = 1'b0;
        bus.en       = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          chk("t2_frozen_data", bus.out_data, hold);
          chk("t2_frozen_valid", w_t'(bus.out_valid), w_t'(1));
        end
        bus.en = 1'b1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = w_t'(w);
      tick();
    end
    idle();
    repeat (12) tick();
    chk("t2_count", w_t'(acc_q.size()), w_t'(20));
    for (int i = 0; i < acc_q.size() && i < 20; i++) chk("t2_order", acc_q[i], w_t'(i + 1));

    // 3: delay change on an empty pipeline
    load(3);
    chk("t3_pending", w_t'(bus.dly_pending), w_t'(1));
    chk("t3_cur_old", w_t'(bus.cur_dly), w_t'(10));
    tick();
    chk("t3_pending_clr", w_t'(bus.dly_pending), w_t'(0));
    chk("t3_cur_new", w_t'(bus.cur_dly), w_t'(3));
    send(w_t'(8'h11), 1'b0);
    n = 1;
    while (!bus.out_valid && n < 30) begin tick(); n++; end
    chk("t3_latency", w_t'(n), w_t'(3));
    chk("t3_data", bus.out_data, w_t'(8'h11));
    repeat (3) tick();

    // 4: delay change requested with 4 words in flight
    load(10);
    tick();
    chk("t4_restore", w_t'(bus.cur_dly), w_t'(10));
    acc_q.delete();
    for (int w = 0; w < 4; w++) send(w_t'(8'h41 + w), 1'b0);
    load(5);
    n = 0;
    while (bus.dly_pending && n < 40) begin
      if (bus.out_valid) chk("t4_cur_hold", w_t'(bus.cur_dly), w_t'(10));
      tick();
      n++;
    end
    chk("t4_apply_edges", w_t'(n), w_t'(10));
    chk("t4_cur_new", w_t'(bus.cur_dly), w_t'(5));
    chk("t4_count", w_t'(acc_q.size()), w_t'(4));
    if (acc_q.size() == 4) chk("t4_last_word", acc_q[3], w_t'(8'h44));

    // 5: flush with 6 words in flight, then clamp checks and flush+load
    load(10);
    tick();
    acc_q.delete();
    for (int w = 0; w < 6; w++) send(w_t'(8'h60 + w), 1'b0);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = w_t'(8'h77);
    tick();
    idle();
    chk("t5_flight_0", w_t'(bus.in_flight), w_t'(0));
    for (int c = 0; c < 10; c++) begin
      chk("t5_no_out", w_t'(bus.out_valid), w_t'(0));
      tick();
    end
    chk("t5_none_accepted", w_t'(acc_q.size()), w_t'(0));
    load(0);
    tick();
    chk("t5_clamp_low", w_t'(bus.cur_dly), w_t'(1));
    load(15);
    tick();
    chk("t5_clamp_high", w_t'(bus.cur_dly), w_t'(10));
    send(w_t'(8'h81), 1'b0);
    send(w_t'(8'h82), 1'b0);
    bus.flush    = 1'b1;
    bus.dly_load = 1'b1;
    bus.dly_sel  = DLY_W'(4);
    tick();
    idle();
    chk("t5_fl_ld_pending", w_t'(bus.dly_pending), w_t'(1));
    tick();
    chk("t5_fl_ld_cur", w_t'(bus.cur_dly), w_t'(4));
    chk("t5_fl_ld_done", w_t'(bus.dly_pending), w_t'(0));

    // 6: frame aborted by reset while word 4 is in flight
    last_seen = 1'b0;
    for (int w = 1; w <= 4; w++) send(w_t'(w), 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_out_valid", w_t'(bus.out_valid), w_t'(0));
    chk("t6_cur_dly", w_t'(bus.cur_dly), w_t'(10));
    chk("t6_in_flight", w_t'(bus.in_flight), w_t'(0));
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("t6_no_out", w_t'(bus.out_valid), w_t'(0));
    end
    chk("t6_no_last", w_t'(last_seen), w_t'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
